// File: rtl/switch_debounce_edge_if.sv
// Switch front-end signal bundle: raw switch levels in, debounced level and
// press/release/long-press strobes out. The master side drives the raw levels.
interface switch_debounce_edge_if #(
   parameter int NUM_SW = 4
);
   logic [NUM_SW-1:0] i_Switch;
   logic [NUM_SW-1:0] o_Switch;
   logic [NUM_SW-1:0] o_Press;
   logic [NUM_SW-1:0] o_Release;
   logic [NUM_SW-1:0] o_Long_Press;

   modport master (
      output i_Switch,
      input  o_Switch,
      input  o_Press,
      input  o_Release,
      input  o_Long_Press
   );

   modport slave (
      input  i_Switch,
      output o_Switch,
      output o_Press,
      output o_Release,
      output o_Long_Press
   );
endinterface

// File: rtl/switch_debounce_edge.sv
// Multi-channel push-button front end: 2-FF synchronizer, counter debouncer
// and registered press/release strobes per channel.
// Optional long-press strobe per channel, built only when LONG_PRESS_EN is
// defined; otherwise o_Long_Press is tied low and no hold counters exist.
module switch_debounce_edge #(
   parameter int NUM_SW         = 4,
   parameter int DEBOUNCE_LIMIT = 250000,
   parameter int CNT_W          = 18,
   parameter int LONG_LIMIT     = 25000000,
   parameter int LONG_W         = 25
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   switch_debounce_edge_if.slave sw_if
);

   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_LIMIT - 1);

   // Reject parameter sets whose counters cannot reach their terminal count.
   if (DEBOUNCE_LIMIT < 2 ||
       longint'(DEBOUNCE_LIMIT - 1) >= (longint'(1) << CNT_W) ||
       longint'(LONG_LIMIT - 1) >= (longint'(1) << LONG_W)) begin : g_param_check
      $error("switch_debounce_edge: counter widths too small for limits");
   end

   logic [NUM_SW-1:0] sync_1;
   logic [NUM_SW-1:0] sync_2;
   logic [NUM_SW-1:0] stable;
   logic [NUM_SW-1:0] press;
   logic [NUM_SW-1:0] rls;
   logic [NUM_SW-1:0] long_pr;

   // Two-stage synchronizer for the asynchronous raw switch levels.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync_1 <= '0;
         sync_2 <= '0;
      end else begin
         sync_1 <= sw_if.i_Switch;
         sync_2 <= sync_1;
      end
   end

   for (genvar n = 0; n < NUM_SW; n++) begin : g_ch
      logic [CNT_W-1:0] cnt;
      logic             stable_q;
      logic             press_q;
      logic             rls_q;

      // Accept the synchronized level after DEBOUNCE_LIMIT consecutive
      // mismatches; any matching sample restarts the count. Strobes are
      // registered alongside the level change so they line up with o_Switch.
      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) begin
            cnt      <= '0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            rls_q    <= 1'b0;
         end else begin
            press_q <= 1'b0;
            rls_q   <= 1'b0;
            if (sync_2[n] == stable_q) begin
               cnt <= '0;
            end else if (cnt == CNT_TC) begin
               cnt      <= '0;
               stable_q <= sync_2[n];
               press_q  <= sync_2[n];
               rls_q    <= ~sync_2[n];
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end

      assign stable[n] = stable_q;
      assign press[n]  = press_q;
      assign rls[n]    = rls_q;

`ifdef LONG_PRESS_EN
      localparam logic [LONG_W-1:0] HOLD_TC = LONG_W'(LONG_LIMIT - 1);
      logic [LONG_W-1:0] hc;
      logic              long_q;

      // Hold counter: the rising edge of stable is hold cycle 0; saturating
      // at the terminal count gives exactly one strobe per hold.
      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) begin
            hc     <= '0;
            long_q <= 1'b0;
         end else begin
            long_q <= 1'b0;
            if (!stable_q) begin
               hc <= '0;
            end else if (hc != HOLD_TC) begin
               hc     <= hc + 1'b1;
               long_q <= (hc == HOLD_TC - 1'b1);
            end
         end
      end

      assign long_pr[n] = long_q;
`else
      assign long_pr[n] = 1'b0;
`endif
   end

   assign sw_if.o_Switch     = stable;
   assign sw_if.o_Press      = press;
   assign sw_if.o_Release    = rls;
   assign sw_if.o_Long_Press = long_pr;

endmodule
